// File: rtl/weapon_projectile_pool.sv
// Projectile slot manager: cooldown-gated firing, aim with dead zone, per-slot
// flight FSM with range/screen retirement and boss hit reporting.
module weapon_projectile_pool #(
  parameter int PROJ_COUNT      = 4,
  parameter int SPEED           = 6,
  parameter int RANGE_FRAMES    = 90,
  parameter int COOLDOWN_FRAMES = 12,
  parameter int DEAD_ZONE       = 8,
  parameter int HIT_HALF_W      = 40,
  parameter int HIT_HALF_H      = 48,
  parameter int SCREEN_W        = 1024,
  parameter int SCREEN_H        = 768
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [1:0]                 game_active,
  input  logic                       mouse_clicked,
  input  logic [11:0]                xpos_MouseCtl,
  input  logic [11:0]                ypos_MouseCtl,
  input  logic [11:0]                origin_x,
  input  logic [11:0]                origin_y,
  input  logic                       facing_left,
  input  logic                       boss_alive,
  input  logic [11:0]                boss_x,
  input  logic [11:0]                boss_y,
  output logic [12*PROJ_COUNT-1:0]   pos_x_proj,
  output logic [12*PROJ_COUNT-1:0]   pos_y_proj,
  output logic [PROJ_COUNT-1:0]      proj_active,
  output logic                       projectile_hit,
  output logic [4:0]                 hit_count,
  output logic                       fire_dropped
);

  localparam int LIFE_W = (RANGE_FRAMES < 2) ? 1 : $clog2(RANGE_FRAMES + 1);
  localparam int CD_W   = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [LIFE_W-1:0] LIFE_LAST     = LIFE_W'(RANGE_FRAMES - 1);
  localparam logic [CD_W-1:0]   COOLDOWN_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic signed [12:0] SPEED_S      = 13'(SPEED);
  localparam logic signed [12:0] DZ_S         = 13'(DEAD_ZONE);
  localparam logic signed [12:0] SCREEN_W_S   = 13'(SCREEN_W);
  localparam logic signed [12:0] SCREEN_H_S   = 13'(SCREEN_H);
  localparam logic [12:0]        HALF_W_U     = 13'(HIT_HALF_W);
  localparam logic [12:0]        HALF_H_U     = 13'(HIT_HALF_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_HIT  = 2'd2
  } slot_state_e;

  slot_state_e              state_r   [PROJ_COUNT];
  slot_state_e              state_nxt_s [PROJ_COUNT];
  logic [11:0]              px_r      [PROJ_COUNT];
  logic [11:0]              py_r      [PROJ_COUNT];
  logic [11:0]              px_nxt_s  [PROJ_COUNT];
  logic [11:0]              py_nxt_s  [PROJ_COUNT];
  logic signed [12:0]       vx_r      [PROJ_COUNT];
  logic signed [12:0]       vy_r      [PROJ_COUNT];
  logic signed [12:0]       vx_nxt_s  [PROJ_COUNT];
  logic signed [12:0]       vy_nxt_s  [PROJ_COUNT];
  logic [LIFE_W-1:0]        life_r    [PROJ_COUNT];
  logic [LIFE_W-1:0]        life_nxt_s [PROJ_COUNT];
  logic signed [12:0]       nx_s      [PROJ_COUNT];
  logic signed [12:0]       ny_s      [PROJ_COUNT];
  logic [PROJ_COUNT-1:0]    off_s;
  logic [PROJ_COUNT-1:0]    in_box_s;

  logic [CD_W-1:0]          cooldown_r;
  logic [CD_W-1:0]          cooldown_nxt_s;
  logic                     click_d_r;
  logic                     fire_req_r;
  logic [PROJ_COUNT-1:0]    active_r;
  logic                     projectile_hit_r;
  logic [4:0]               hit_count_r;
  logic                     fire_dropped_r;

  logic                     playing_s;
  logic                     found_s;
  logic                     drop_s;
  logic [4:0]               hit_cnt_s;
  logic signed [12:0]       dx_s;
  logic signed [12:0]       dy_s;
  logic signed [12:0]       aim_vx_s;
  logic signed [12:0]       aim_vy_s;

  function automatic logic [12:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    logic signed [12:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = d[12] ? 13'(-d) : 13'(d);
  endfunction

  assign playing_s = (game_active == 2'd1);
  assign dx_s = $signed({1'b0, xpos_MouseCtl}) - $signed({1'b0, origin_x});
  assign dy_s = $signed({1'b0, ypos_MouseCtl}) - $signed({1'b0, origin_y});

  // Launch velocity from cursor offset; cursor inside the dead zone falls back to facing.
  always_comb begin
    aim_vx_s = 13'sd0;
    aim_vy_s = 13'sd0;
    if (dx_s > DZ_S) begin
      aim_vx_s = SPEED_S;
    end else if (dx_s < -DZ_S) begin
      aim_vx_s = -SPEED_S;
    end else begin
      aim_vx_s = 13'sd0;
    end
    if (dy_s > DZ_S) begin
      aim_vy_s = SPEED_S;
    end else if (dy_s < -DZ_S) begin
      aim_vy_s = -SPEED_S;
    end else begin
      aim_vy_s = 13'sd0;
    end
    if (aim_vx_s == 13'sd0 && aim_vy_s == 13'sd0) begin
      aim_vx_s = facing_left ? -SPEED_S : SPEED_S;
    end else begin
      aim_vx_s = aim_vx_s;
    end
  end

  // Per-slot next position, screen-exit test and boss hitbox test on the pre-move position.
  always_comb begin
    for (int i = 0; i < PROJ_COUNT; i++) begin
      nx_s[i]     = $signed({1'b0, px_r[i]}) + vx_r[i];
      ny_s[i]     = $signed({1'b0, py_r[i]}) + vy_r[i];
      off_s[i]    = (nx_s[i] < 13'sd0) || (nx_s[i] >= SCREEN_W_S) ||
                    (ny_s[i] < 13'sd0) || (ny_s[i] >= SCREEN_H_S);
      in_box_s[i] = (abs_diff(px_r[i], boss_x) <= HALF_W_U) &&
                    (abs_diff(py_r[i], boss_y) <= HALF_H_U);
    end
  end

  // Slot FSMs, cooldown and fire arbitration; allocation only sees slots idle this cycle.
  always_comb begin
    cooldown_nxt_s = cooldown_r;
    found_s        = 1'b0;
    drop_s         = 1'b0;
    hit_cnt_s      = 5'd0;
    for (int i = 0; i < PROJ_COUNT; i++) begin
      state_nxt_s[i] = state_r[i];
      px_nxt_s[i]    = px_r[i];
      py_nxt_s[i]    = py_r[i];
      vx_nxt_s[i]    = vx_r[i];
      vy_nxt_s[i]    = vy_r[i];
      life_nxt_s[i]  = life_r[i];
    end

    if (!playing_s) begin
      cooldown_nxt_s = '0;
      for (int i = 0; i < PROJ_COUNT; i++) begin
        state_nxt_s[i] = S_IDLE;
      end
    end else begin
      for (int i = 0; i < PROJ_COUNT; i++) begin
        case (state_r[i])
          S_IDLE: begin
            state_nxt_s[i] = S_IDLE;
          end
          S_FLY: begin
            if (!frame_tick) begin
              state_nxt_s[i] = S_FLY;
            end else if (boss_alive && in_box_s[i]) begin
              state_nxt_s[i] = S_HIT;
              hit_cnt_s      = hit_cnt_s + 5'd1;
            end else if (life_r[i] == LIFE_LAST) begin
              state_nxt_s[i] = S_IDLE;
            end else if (off_s[i]) begin
              state_nxt_s[i] = S_IDLE;
            end else begin
              px_nxt_s[i]   = nx_s[i][11:0];
              py_nxt_s[i]   = ny_s[i][11:0];
              life_nxt_s[i] = life_r[i] + LIFE_W'(1'b1);
            end
          end
          S_HIT: begin
            if (frame_tick) begin
              state_nxt_s[i] = S_IDLE;
            end else begin
              state_nxt_s[i] = S_HIT;
            end
          end
          default: begin
            state_nxt_s[i] = S_IDLE;
          end
        endcase
      end

      if (fire_req_r && cooldown_r == '0) begin
        cooldown_nxt_s = COOLDOWN_LOAD;
        for (int i = 0; i < PROJ_COUNT; i++) begin
          if (!found_s && state_r[i] == S_IDLE) begin
            found_s        = 1'b1;
            state_nxt_s[i] = S_FLY;
            px_nxt_s[i]    = origin_x;
            py_nxt_s[i]    = origin_y;
            vx_nxt_s[i]    = aim_vx_s;
            vy_nxt_s[i]    = aim_vy_s;
            life_nxt_s[i]  = '0;
          end else begin
            found_s = found_s;
          end
        end
        drop_s = !found_s;
      end else if (frame_tick && cooldown_r != '0) begin
        cooldown_nxt_s = cooldown_r - CD_W'(1'b1);
      end else begin
        cooldown_nxt_s = cooldown_r;
      end
    end
  end

  // State, kinematics, cooldown, click edge and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PROJ_COUNT; i++) begin
        state_r[i] <= S_IDLE;
        px_r[i]    <= 12'd0;
        py_r[i]    <= 12'd0;
        vx_r[i]    <= 13'sd0;
        vy_r[i]    <= 13'sd0;
        life_r[i]  <= '0;
      end
      cooldown_r       <= '0;
      click_d_r        <= 1'b0;
      fire_req_r       <= 1'b0;
      active_r         <= '0;
      projectile_hit_r <= 1'b0;
      hit_count_r      <= 5'd0;
      fire_dropped_r   <= 1'b0;
    end else begin
      for (int i = 0; i < PROJ_COUNT; i++) begin
        state_r[i]  <= state_nxt_s[i];
        px_r[i]     <= px_nxt_s[i];
        py_r[i]     <= py_nxt_s[i];
        vx_r[i]     <= vx_nxt_s[i];
        vy_r[i]     <= vy_nxt_s[i];
        life_r[i]   <= life_nxt_s[i];
        active_r[i] <= (state_nxt_s[i] == S_FLY);
      end
      cooldown_r       <= cooldown_nxt_s;
      click_d_r        <= mouse_clicked;
      fire_req_r       <= mouse_clicked & ~click_d_r;
      projectile_hit_r <= (hit_cnt_s != 5'd0);
      hit_count_r      <= hit_cnt_s;
      fire_dropped_r   <= drop_s;
    end
  end

  // Pack slot positions onto the flat output buses.
  always_comb begin
    pos_x_proj = '0;
    pos_y_proj = '0;
    for (int i = 0; i < PROJ_COUNT; i++) begin
      pos_x_proj[12*i +: 12] = px_r[i];
      pos_y_proj[12*i +: 12] = py_r[i];
    end
  end

  assign proj_active    = active_r;
  assign projectile_hit = projectile_hit_r;
  assign hit_count      = hit_count_r;
  assign fire_dropped   = fire_dropped_r;

endmodule

// File: tb/tb_weapon_projectile_pool.sv
// Directed bench for weapon_projectile_pool: aim/retire vector table plus
// hand-written cooldown, pool-exhaustion, hit, range and reset sequences.
module tb_weapon_projectile_pool;

  localparam int PC = 4;

  logic            clk;
  logic            rst;
  logic            frame_tick;
  logic [1:0]      game_active;
  logic            mouse_clicked;
  logic [11:0]     xpos_MouseCtl, ypos_MouseCtl, origin_x, origin_y;
  logic            facing_left, boss_alive;
  logic [11:0]     boss_x, boss_y;
  logic [12*PC-1:0] pos_x_proj, pos_y_proj;
  logic [PC-1:0]   proj_active;
  logic            projectile_hit;
  logic [4:0]      hit_count;
  logic            fire_dropped;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic       last_hit, after_hit, last_drop, drop_after;
  logic [4:0] last_cnt;

  weapon_projectile_pool dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
    .mouse_clicked(mouse_clicked), .xpos_MouseCtl(xpos_MouseCtl),
    .ypos_MouseCtl(ypos_MouseCtl), .origin_x(origin_x), .origin_y(origin_y),
    .facing_left(facing_left), .boss_alive(boss_alive), .boss_x(boss_x),
    .boss_y(boss_y), .pos_x_proj(pos_x_proj), .pos_y_proj(pos_y_proj),
    .proj_active(proj_active), .projectile_hit(projectile_hit),
    .hit_count(hit_count), .fire_dropped(fire_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] mx, my, ox, oy;
    logic        fl;
    int          ticks;
    logic        act;
    logic [11:0] ex, ey;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [11:0] sx(input int i);
    return pos_x_proj[12*i +: 12];
  endfunction

  function automatic logic [11:0] sy(input int i);
    return pos_y_proj[12*i +: 12];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end on a falling clock edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    last_hit = projectile_hit;
    last_cnt = hit_count;
    @(negedge clk);
    after_hit = projectile_hit;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic click();
    mouse_clicked = 1'b1;
    @(negedge clk);
    mouse_clicked = 1'b0;
    @(negedge clk);
    last_drop = fire_dropped;
    @(negedge clk);
    drop_after = fire_dropped;
  endtask

  task automatic clear_pool();
    game_active = 2'd0;
    @(negedge clk);
    game_active = 2'd1;
    @(negedge clk);
  endtask

  task automatic aim(input logic [11:0] mx, my, ox, oy, input logic fl);
    xpos_MouseCtl = mx; ypos_MouseCtl = my;
    origin_x = ox; origin_y = oy; facing_left = fl;
  endtask

  initial begin
    //            mx    my    ox    oy   fl tk act  ex    ey
    vecs[0]  = '{12'd700,  12'd400, 12'd500,  12'd400, 1'b0, 5, 1'b1, 12'd530,  12'd400};
    vecs[1]  = '{12'd503,  12'd402, 12'd500,  12'd400, 1'b1, 1, 1'b1, 12'd494,  12'd400};
    vecs[2]  = '{12'd503,  12'd402, 12'd500,  12'd400, 1'b0, 1, 1'b1, 12'd506,  12'd400};
    vecs[3]  = '{12'd300,  12'd200, 12'd500,  12'd400, 1'b0, 3, 1'b1, 12'd482,  12'd382};
    vecs[4]  = '{12'd500,  12'd700, 12'd500,  12'd400, 1'b0, 2, 1'b1, 12'd500,  12'd412};
    vecs[5]  = '{12'd508,  12'd400, 12'd500,  12'd400, 1'b1, 1, 1'b1, 12'd494,  12'd400};
    vecs[6]  = '{12'd509,  12'd400, 12'd500,  12'd400, 1'b1, 1, 1'b1, 12'd506,  12'd400};
    vecs[7]  = '{12'd491,  12'd391, 12'd500,  12'd400, 1'b0, 1, 1'b1, 12'd494,  12'd394};
    vecs[8]  = '{12'd700,  12'd400, 12'd500,  12'd400, 1'b0, 0, 1'b1, 12'd500,  12'd400};
    vecs[9]  = '{12'd1200, 12'd400, 12'd1020, 12'd400, 1'b0, 1, 1'b0, 12'd1020, 12'd400};
    vecs[10] = '{12'd1200, 12'd400, 12'd1017, 12'd400, 1'b0, 1, 1'b1, 12'd1023, 12'd400};
    vecs[11] = '{12'd0,    12'd400, 12'd5,    12'd400, 1'b1, 1, 1'b0, 12'd5,    12'd400};
    vecs[12] = '{12'd0,    12'd400, 12'd6,    12'd400, 1'b1, 1, 1'b1, 12'd0,    12'd400};
    vecs[13] = '{12'd500,  12'd1000, 12'd500, 12'd762, 1'b0, 1, 1'b0, 12'd500,  12'd762};
    vecs[14] = '{12'd500,  12'd1000, 12'd500, 12'd761, 1'b0, 1, 1'b1, 12'd500,  12'd767};

    rst = 1'b0; frame_tick = 1'b0; game_active = 2'd1; mouse_clicked = 1'b0;
    aim(12'd0, 12'd0, 12'd0, 12'd0, 1'b0);
    boss_alive = 1'b0; boss_x = 12'd600; boss_y = 12'd400;
    @(negedge clk); @(negedge clk);
    check("reset_active", proj_active, 4'b0000);
    check("reset_pulses", {projectile_hit, hit_count, fire_dropped}, 7'd0);
    check("reset_pos", {pos_x_proj, pos_y_proj}, 96'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      clear_pool();
      aim(vecs[v].mx, vecs[v].my, vecs[v].ox, vecs[v].oy, vecs[v].fl);
      click();
      ticks(vecs[v].ticks);
      check($sformatf("vec%0d_slot0", v), {proj_active[0], sx(0), sy(0)},
            {vecs[v].act, vecs[v].ex, vecs[v].ey});
    end

    // Launch coinciding with frame_tick: new slot waits for the next tick.
    clear_pool();
    aim(12'd700, 12'd400, 12'd500, 12'd400, 1'b0);
    mouse_clicked = 1'b1;
    @(negedge clk);
    mouse_clicked = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("same_cycle_launch", {proj_active[0], sx(0)}, {1'b1, 12'd500});
    tick();
    check("same_cycle_next_tick", sx(0), 12'd506);

    // Cooldown: clicks at 5 and 11 frames are discarded, at 12 accepted.
    clear_pool();
    aim(12'd700, 12'd400, 12'd100, 12'd400, 1'b0);
    click();
    ticks(5);
    click();
    check("cooldown_5", {proj_active, last_drop}, {4'b0001, 1'b0});
    ticks(6);
    click();
    check("cooldown_11", {proj_active, last_drop}, {4'b0001, 1'b0});
    tick();
    click();
    check("cooldown_12", {proj_active, last_drop}, {4'b0011, 1'b0});

    // Pool exhaustion: fifth accepted click has no free slot.
    clear_pool();
    for (int k = 0; k < 4; k++) begin
      click();
      ticks(13);
    end
    check("pool_full", proj_active, 4'b1111);
    click();
    check("pool_drop", {last_drop, proj_active}, {1'b1, 4'b1111});
    check("pool_drop_pulse", drop_after, 1'b0);
    click();
    check("drop_loads_cooldown", last_drop, 1'b0);
    check("pool_slot0_pos", sx(0), 12'd412);

    // Two slots inside the boss box: no hit while boss dead, both hit when alive.
    clear_pool();
    aim(12'd700, 12'd400, 12'd560, 12'd400, 1'b0);
    click();
    ticks(12);
    aim(12'd700, 12'd400, 12'd600, 12'd400, 1'b0);
    click();
    check("hit_setup", {proj_active, sx(0), sx(1)}, {4'b0011, 12'd632, 12'd600});
    tick();
    check("boss_dead_no_hit", {last_hit, last_cnt, proj_active, sx(0), sx(1)},
          {1'b0, 5'd0, 4'b0011, 12'd638, 12'd606});
    boss_alive = 1'b1;
    tick();
    check("hit_pulse", {last_hit, last_cnt, proj_active}, {1'b1, 5'd2, 4'b0000});
    check("hit_pulse_one_cycle", {after_hit, hit_count}, {1'b0, 5'd0});
    check("hit_pos_hold", {sx(0), sx(1)}, {12'd638, 12'd606});
    tick();
    check("hit_no_repeat", last_hit, 1'b0);
    ticks(9);
    click();
    check("hit_slot_reused", proj_active, 4'b0001);
    boss_alive = 1'b0;

    // Range limit: retire on the 90th tick without moving.
    clear_pool();
    aim(12'd700, 12'd400, 12'd100, 12'd400, 1'b0);
    click();
    ticks(89);
    check("range_89", {proj_active[0], sx(0)}, {1'b1, 12'd634});
    tick();
    check("range_90", {proj_active[0], sx(0)}, {1'b0, 12'd634});

    // Leaving play forces slots idle but keeps positions.
    clear_pool();
    click();
    ticks(2);
    clear_pool();
    check("inactive_clear", {proj_active, sx(0)}, {4'b0000, 12'd112});

    // Asynchronous reset with three slots flying.
    clear_pool();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) ticks(12);
      click();
    end
    check("pre_reset", proj_active, 4'b0111);
    rst = 1'b0;
    #1;
    check("reset_mid_active", proj_active, 4'b0000);
    check("reset_mid_pos", {sx(0), sx(1), sx(2)}, 36'd0);
    check("reset_mid_pulses", {projectile_hit, hit_count, fire_dropped}, 7'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    click();
    check("post_reset_launch", {proj_active, sx(0)}, {4'b0001, 12'd100});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
